// File: rtl/uart_tx_io.sv
// Memory-mapped UART transmitter: DATA/STATUS registers on the IO page, a transmit buffer and an 8N1 serializer.
// Define UART_TX_FIFO_EN for a 4-entry transmit FIFO; otherwise a single holding register is used.
module uart_tx_io #(
    parameter int CLKS_PER_BIT = 104,
    parameter int IO_BIT       = 22
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_rstrb,
    output logic [31:0] mem_rdata,
    output logic        TXD,
    output logic        tx_busy
);

    // state  | meaning
    // S_IDLE | line high, waiting for a buffered byte
    // S_START| start bit (TXD=0)
    // S_DATA | 8 data bits, LSB first
    // S_STOP | stop bit (TXD=1); chains straight into S_START if more data waits
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [2:0]  DEPTH_L    = 3'(DEPTH);
    localparam logic [15:0] BIT_RELOAD = 16'(CLKS_PER_BIT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] bit_cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shift_reg;
    logic [2:0]  buf_count;
    logic [7:0]  buf_head;
    logic        overflow;
    logic        pop;
    logic        bit_end;

    logic        io_sel;
    logic [1:0]  reg_idx;
    logic        push_req;
    logic        ovf_clr;
    logic        buf_full;
    logic        buf_empty;
    logic        push_ok;
    logic [31:0] status_word;
    logic        unused_bits;

    assign io_sel      = mem_addr[IO_BIT];
    assign reg_idx     = mem_addr[3:2];
    assign push_req    = io_sel && (reg_idx == 2'd0) && mem_wmask[0];
    assign ovf_clr     = io_sel && (reg_idx == 2'd1) && mem_wmask[0];
    assign buf_full    = (buf_count == DEPTH_L);
    assign buf_empty   = (buf_count == 3'd0);
    // A full buffer still takes a push when the serializer drains an entry on the same edge.
    assign push_ok     = push_req && (!buf_full || pop);
    assign bit_end     = (bit_cnt == 16'd0);
    assign tx_busy     = (state != S_IDLE) || !buf_empty;
    assign status_word = {25'd0, buf_count, 1'b0, overflow, buf_full, tx_busy};
    assign unused_bits = ^{mem_addr, mem_wdata[31:8], mem_wmask[3:1]};

`ifdef UART_TX_FIFO_EN
    logic [7:0] fifo_mem [4];
    logic [1:0] wr_ptr;
    logic [1:0] rd_ptr;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 2'd1;
            if (pop)     rd_ptr <= rd_ptr + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wr_ptr] <= mem_wdata[7:0];
    end

    assign buf_head = fifo_mem[rd_ptr];
`else
    logic [7:0] hold_reg;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)      hold_reg <= 8'd0;
        else if (push_ok) hold_reg <= mem_wdata[7:0];
    end

    assign buf_head = hold_reg;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            buf_count <= 3'd0;
        end else begin
            case ({push_ok, pop})
                2'b10:   buf_count <= buf_count + 3'd1;
                2'b01:   buf_count <= buf_count - 3'd1;
                default: buf_count <= buf_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)                          overflow <= 1'b0;
        else if (push_req && buf_full && !pop) overflow <= 1'b1;
        else if (ovf_clr)                     overflow <= 1'b0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            mem_rdata <= 32'd0;
        end else if (mem_rstrb) begin
            mem_rdata <= (io_sel && (reg_idx == 2'd1)) ? status_word : 32'd0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (!buf_empty) state_nxt = S_START;
            S_START: if (bit_end) state_nxt = S_DATA;
            S_DATA:  if (bit_end && (bit_idx == 3'd7)) state_nxt = S_STOP;
            S_STOP:  if (bit_end) state_nxt = buf_empty ? S_IDLE : S_START;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        pop = 1'b0;
        TXD = 1'b1;
        case (state)
            S_IDLE:  pop = !buf_empty;
            S_START: TXD = 1'b0;
            S_DATA:  TXD = shift_reg[bit_idx];
            S_STOP:  pop = bit_end && !buf_empty;
            default: TXD = 1'b1;
        endcase
    end

    // Bit timer reloads at every bit boundary and parks at 0 once the line goes idle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bit_cnt   <= 16'd0;
            bit_idx   <= 3'd0;
            shift_reg <= 8'd0;
        end else begin
            if (pop || (((state == S_START) || (state == S_DATA)) && bit_end))
                bit_cnt <= BIT_RELOAD;
            else if (!bit_end)
                bit_cnt <= bit_cnt - 16'd1;

            if ((state == S_DATA) && bit_end)
                bit_idx <= bit_idx + 3'd1;

            if (pop)
                shift_reg <= buf_head;
        end
    end

endmodule

// File: tb/tb_uart_tx_io.sv
// Bench for uart_tx_io: a frame-level line model checked every cycle, plus directed scenarios with literal expectations.
module tb_uart_tx_io;

    localparam int CPB   = 4;
    localparam int FRAME = 10 * CPB;
`ifdef UART_TX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [31:0] mem_addr = 32'd0;
    logic [31:0] mem_wdata = 32'd0;
    logic [3:0]  mem_wmask = 4'd0;
    logic        mem_rstrb = 1'b0;
    logic [31:0] mem_rdata;
    logic        TXD;
    logic        tx_busy;

    uart_tx_io #(.CLKS_PER_BIT(CPB), .IO_BIT(22)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .TXD       (TXD),
        .tx_busy   (tx_busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Line model: a queue of waiting bytes and the position inside the frame being sent.
    logic [7:0]  m_q [$];
    logic [7:0]  m_cur = 8'd0;
    int          m_pos = 0;
    bit          m_active = 1'b0;
    bit          m_ovf = 1'b0;
    logic [31:0] m_rdata = 32'd0;
    int          m_occ;
    bit          m_busy_pre;
    bit          m_full_pre;

    function automatic logic line_bit(input logic [7:0] b, input int p);
        int k;
        k = p / CPB;
        if (k == 0) return 1'b0;
        if (k == 9) return 1'b1;
        return b[k-1];
    endfunction

    initial begin : line_model
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) begin
                m_q.delete();
                m_active = 1'b0;
                m_pos    = 0;
                m_ovf    = 1'b0;
                m_rdata  = 32'd0;
                m_cur    = 8'd0;
            end else begin
                m_occ      = m_q.size();
                m_busy_pre = m_active || (m_occ != 0);
                m_full_pre = (m_occ == DEPTH);
                if (mem_rstrb)
                    m_rdata = (mem_addr[22] && mem_addr[3:2] == 2'd1) ?
                              {25'd0, m_occ[2:0], 1'b0, m_ovf, m_full_pre, m_busy_pre} : 32'd0;
                if (m_active) begin
                    m_pos++;
                    if (m_pos == FRAME) begin
                        if (m_q.size() != 0) begin
                            m_cur = m_q.pop_front();
                            m_pos = 0;
                        end else begin
                            m_active = 1'b0;
                        end
                    end
                end else if (m_q.size() != 0) begin
                    m_cur    = m_q.pop_front();
                    m_pos    = 0;
                    m_active = 1'b1;
                end
                if (mem_addr[22] && mem_addr[3:2] == 2'd0 && mem_wmask[0]) begin
                    if (m_q.size() < DEPTH) m_q.push_back(mem_wdata[7:0]);
                    else                    m_ovf = 1'b1;
                end
                if (mem_addr[22] && mem_addr[3:2] == 2'd1 && mem_wmask[0])
                    m_ovf = 1'b0;
            end
        end
    end

    initial begin : compare
        forever begin
            @(negedge clk);
            check("model_txd", {31'd0, TXD},
                  {31'd0, (m_active ? line_bit(m_cur, m_pos) : 1'b1)});
            check("model_busy", {31'd0, tx_busy},
                  {31'd0, (m_active || (m_q.size() != 0))});
            check("model_rdata", mem_rdata, m_rdata);
        end
    end

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_addr  = a;
        mem_wdata = d;
        mem_wmask = 4'b0001;
        @(negedge clk);
        mem_wmask = 4'b0000;
    endtask

    task automatic rd(input logic [31:0] a);
        mem_addr  = a;
        mem_rstrb = 1'b1;
        @(negedge clk);
        mem_rstrb = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (tx_busy && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check(name, {31'd0, tx_busy}, 32'd0);
        repeat (2) @(negedge clk);
    endtask

    logic [FRAME-1:0] cap;
    logic [9:0]       exp55 = 10'b1010101010;
    int               n_wait;
    int               n_low;

    initial begin : stimulus
        repeat (3) @(negedge clk);
        check("rst_txd", {31'd0, TXD}, 32'd1);
        check("rst_busy", {31'd0, tx_busy}, 32'd0);
        check("rst_rdata", mem_rdata, 32'd0);
        #2 resetn = 1'b1;
        @(negedge clk);

        // single 0x55 frame
        wr(32'h0040_0000, 32'h55);
        check("busy_after_push", {31'd0, tx_busy}, 32'd1);
        check("txd_before_start", {31'd0, TXD}, 32'd1);
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            cap[k] = TXD;
        end
        for (int b = 0; b < 10; b++)
            check($sformatf("bit55_%0d", b),
                  {28'd0, cap[b*CPB+3], cap[b*CPB+2], cap[b*CPB+1], cap[b*CPB]},
                  exp55[b] ? 32'hF : 32'h0);
        @(negedge clk);
        check("busy_after_stop", {31'd0, tx_busy}, 32'd0);
        check("txd_after_stop", {31'd0, TXD}, 32'd1);

        // register reads and accesses outside the IO page
        rd(32'h0040_0004);
        check("status_idle", mem_rdata, 32'd0);
        rd(32'h0000_0004);
        wr(32'h0000_0000, 32'h3C);
        wr(32'h0040_0008, 32'h77);
        rd(32'h0040_0008);
        check("unmapped_read", mem_rdata, 32'd0);
        repeat (3) @(negedge clk);
        check("io_clear_busy", {31'd0, tx_busy}, 32'd0);
        check("io_clear_txd", {31'd0, TXD}, 32'd1);

        // push into a full buffer on the very edge the serializer drains it
        for (int i = 0; i < DEPTH + 1; i++) wr(32'h0040_0000, 32'h20 + i);
        n_wait = 0;
        while (!(m_active && m_pos == FRAME - 1) && n_wait < 500) begin
            @(negedge clk);
            n_wait++;
        end
        check("wait_stop_end", (n_wait < 500) ? 32'd1 : 32'd0, 32'd1);
        wr(32'h0040_0000, 32'h3A);
        rd(32'h0040_0004);
        check("status_pop_push", mem_rdata, (DEPTH == 4) ? 32'h43 : 32'h13);
        wait_idle("idle_after_pop_push");

`ifdef UART_TX_FIFO_EN
        // four back-to-back frames
        for (int i = 1; i <= 4; i++) wr(32'h0040_0000, i);
        rd(32'h0040_0004);
        check("status_four", mem_rdata, 32'h31);
        n_wait = 0;
        while (tx_busy && n_wait < 400) begin
            @(negedge clk);
            n_wait++;
        end
        check("four_frames_span", n_wait, 32'd157);
        repeat (2) @(negedge clk);

        // overflow on a 6th push, then clear
        for (int i = 0; i < 5; i++) wr(32'h0040_0000, 32'h10 + i);
        wr(32'h0040_0000, 32'hEE);
        rd(32'h0040_0004);
        check("status_overflow", mem_rdata, 32'h47);
        wr(32'h0040_0004, 32'h1);
        rd(32'h0040_0004);
        check("status_ovf_cleared", mem_rdata, 32'h43);
        wait_idle("idle_after_overflow");
`else
        // holding register: second push lands on the pop edge, third is dropped
        wr(32'h0040_0000, 32'h61);
        wr(32'h0040_0000, 32'h62);
        rd(32'h0040_0004);
        check("status_second_ok", mem_rdata, 32'h13);
        wr(32'h0040_0000, 32'h63);
        rd(32'h0040_0004);
        check("status_third_drop", mem_rdata, 32'h17);
        wr(32'h0040_0004, 32'h1);
        rd(32'h0040_0004);
        check("status_ovf_cleared", mem_rdata, 32'h13);
        wait_idle("idle_after_holding");
`endif

        // reset in the middle of the data bits of 0xA5
        wr(32'h0040_0000, 32'hA5);
        repeat (15) @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        check("midreset_txd", {31'd0, TXD}, 32'd1);
        check("midreset_busy", {31'd0, tx_busy}, 32'd0);
        check("midreset_rdata", mem_rdata, 32'd0);
        @(negedge clk);
        #2 resetn = 1'b1;
        n_low = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (TXD == 1'b0 || tx_busy) n_low++;
        end
        check("no_residual_frame", n_low, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
